// File: rtl/jamma_pkg.sv
// -----------------------------------------------------------------------------
// jamma_pkg
// Shared definitions for the JAMMA control-input scanner.
//   - scan_state_t : scanner FSM encoding (ST_SETTLE, ST_SAMPLE, ST_COMMIT)
//   - JOY_BITS     : width of one player bank on the JAMMA bus
//   - UP..START    : bit positions of the individual controls within a bank
// -----------------------------------------------------------------------------
package jamma_pkg;

   localparam int JOY_BITS = 8;

   // Bit positions inside one active-low bank byte
   localparam int UP    = 0;
   localparam int DOWN  = 1;
   localparam int LEFT  = 2;
   localparam int RIGHT = 3;
   localparam int B1    = 4;
   localparam int B2    = 5;
   localparam int B3    = 6;
   localparam int START = 7;

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_COMMIT = 2'd2
   } scan_state_t;

endpackage

// File: rtl/jamma_coin_stretch.sv
// -----------------------------------------------------------------------------
// jamma_coin_stretch
// One coin channel: 2-FF synchroniser, falling-edge detect and a hold
// counter that stretches short coin pulses to at least COIN_HOLD cycles.
// Pin-to-output latency is 3 cycles (2 sync stages + output register).
//
// Ports
//   i_pclk     in   system clock
//   i_reset_n  in   synchronous active-low reset
//   i_coin_n   in   raw coin switch, active-low, asynchronous
//   o_coin_n   out  synchronised, stretched coin, active-low
// -----------------------------------------------------------------------------
module jamma_coin_stretch #(
   parameter int COIN_HOLD = 16
) (
   input  logic i_pclk,
   input  logic i_reset_n,
   input  logic i_coin_n,
   output logic o_coin_n
);

   localparam int CNT_W = $clog2(COIN_HOLD + 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_prev;
   logic             r_out_n;
   logic [CNT_W-1:0] r_cnt;

   logic             w_fall;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_fall = r_prev & ~r_sync;

   // A fresh edge always reloads, even on the cycle the counter would expire
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_fall) begin
         w_cnt_next = CNT_W'(COIN_HOLD);
      end else if (r_cnt != '0) begin
         w_cnt_next = r_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_reset_n) begin
         r_meta  <= 1'b1;
         r_sync  <= 1'b1;
         r_prev  <= 1'b1;
         r_cnt   <= '0;
         r_out_n <= 1'b1;
      end else begin
         r_meta  <= i_coin_n;
         r_sync  <= r_meta;
         r_prev  <= r_sync;
         r_cnt   <= w_cnt_next;
         // Low while the (updated) counter runs or the coin is still held
         r_out_n <= ~((w_cnt_next != '0) | ~r_sync);
      end
   end

   assign o_coin_n = r_out_n;

endmodule

// File: rtl/jamma_input_mux.sv
// -----------------------------------------------------------------------------
// jamma_input_mux
// Time-multiplexed JAMMA joystick scanner. Drives o_jsel to pick one of
// NUM_PLAYERS banks on the shared active-low bus, waits SETTLE_CYCLES, then
// latches the bank into o_joy_out_n. Coin inputs are synchronised and
// pulse-stretched by one jamma_coin_stretch per player.
//
// Build option: define JAMMA_DEBOUNCE_EN to require DEB_DEPTH consecutive
// agreeing scan samples before any joystick bit changes. Without it the
// sampled byte is copied straight to the output.
//
// Ports
//   i_pclk         in   system clock
//   i_reset_n      in   synchronous active-low reset
//   i_jjoy_n       in   shared JAMMA bus, active-low, asynchronous
//   i_local_joy_n  in   on-board joystick, active-low, merged into bank 0
//   i_coin_n       in   coin switches, active-low, asynchronous
//   o_jsel         out  bank select to the external multiplexer
//   o_joy_out_n    out  per-bank state, bank p at bits [8p+7:8p]
//   o_coin_out_n   out  synchronised, stretched coins, active-low
//   o_scan_done    out  high during the COMMIT cycle of the last bank
// -----------------------------------------------------------------------------
module jamma_input_mux
   import jamma_pkg::*;
#(
   parameter int NUM_PLAYERS   = 2,
   parameter int SEL_W         = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int DEB_DEPTH     = 3,
   parameter int COIN_HOLD     = 16
) (
   input  logic                            i_pclk,
   input  logic                            i_reset_n,
   input  logic [JOY_BITS-1:0]             i_jjoy_n,
   input  logic [JOY_BITS-1:0]             i_local_joy_n,
   input  logic [NUM_PLAYERS-1:0]          i_coin_n,
   output logic [SEL_W-1:0]                o_jsel,
   output logic [JOY_BITS*NUM_PLAYERS-1:0] o_joy_out_n,
   output logic [NUM_PLAYERS-1:0]          o_coin_out_n,
   output logic                            o_scan_done
);

   localparam int BANK_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int SET_W  = 8;
   localparam logic [SET_W-1:0] SETTLE_LAST =
      SET_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

   genvar gi;
   genvar gb;

   // Out-of-range parameters leave this named marker in the hierarchy
   if ((NUM_PLAYERS < 1) || (NUM_PLAYERS > 4) ||
       (DEB_DEPTH < 2) || (DEB_DEPTH > 8)) begin : g_param_out_of_range
   end

   scan_state_t         r_state;
   scan_state_t         w_state_next;
   logic [BANK_W-1:0]   r_bank;
   logic [BANK_W-1:0]   w_bank_next;
   logic [SET_W-1:0]    r_settle_cnt;
   logic [SET_W-1:0]    w_settle_next;
   logic                r_scan_done;
   logic [JOY_BITS-1:0] r_jjoy_meta;
   logic [JOY_BITS-1:0] r_jjoy_sync;
   logic [JOY_BITS-1:0] w_capture;
   logic                w_last_bank;

   assign w_last_bank = (r_bank == BANK_W'(NUM_PLAYERS - 1));

   // ---------------------------------------------------------------
   // Bus synchroniser
   // ---------------------------------------------------------------
   always_ff @(posedge i_pclk) begin
      if (!i_reset_n) begin
         r_jjoy_meta <= '1;
         r_jjoy_sync <= '1;
      end else begin
         r_jjoy_meta <= i_jjoy_n;
         r_jjoy_sync <= r_jjoy_meta;
      end
   end

   // The synchroniser only delivers the newly selected bank once the
   // settle and SAMPLE cycles have flushed it, so the byte is taken from
   // the synchroniser output while in COMMIT.
   assign w_capture = r_jjoy_sync &
                      ((r_bank == '0) ? i_local_joy_n : {JOY_BITS{1'b1}});

   // ---------------------------------------------------------------
   // Scanner FSM
   // ---------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_bank_next   = r_bank;
      w_settle_next = r_settle_cnt;
      case (r_state)
         ST_SETTLE: begin
            if ((SETTLE_CYCLES == 0) || (r_settle_cnt == SETTLE_LAST)) begin
               w_state_next  = ST_SAMPLE;
               w_settle_next = '0;
            end else begin
               w_settle_next = r_settle_cnt + 1'b1;
            end
         end
         ST_SAMPLE: begin
            w_state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_bank_next  = w_last_bank ? '0 : r_bank + 1'b1;
            w_state_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
         end
         default: begin
            w_state_next  = ST_SETTLE;
            w_settle_next = '0;
         end
      endcase
   end

   always_ff @(posedge i_pclk) begin
      if (!i_reset_n) begin
         r_state      <= ST_SETTLE;
         r_bank       <= '0;
         r_settle_cnt <= '0;
         r_scan_done  <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_bank       <= w_bank_next;
         r_settle_cnt <= w_settle_next;
         // Registered so it is high exactly during the last bank's COMMIT
         r_scan_done  <= (w_state_next == ST_COMMIT) && w_last_bank;
      end
   end

   assign o_jsel      = SEL_W'(r_bank);
   assign o_scan_done = r_scan_done;

   // ---------------------------------------------------------------
   // Per-bank output registers
   // ---------------------------------------------------------------
   for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_bank
      logic w_commit_here;
      assign w_commit_here = (r_state == ST_COMMIT) && (r_bank == BANK_W'(gi));

`ifdef JAMMA_DEBOUNCE_EN
      for (gb = 0; gb < JOY_BITS; gb++) begin : g_bit
         logic [DEB_DEPTH-1:0] r_hist;
         logic [DEB_DEPTH-1:0] w_hist_next;
         logic                 r_out_n;

         assign w_hist_next = {r_hist[DEB_DEPTH-2:0], w_capture[gb]};

         // Output only moves when every history entry agrees
         always_ff @(posedge i_pclk) begin
            if (!i_reset_n) begin
               r_hist  <= '1;
               r_out_n <= 1'b1;
            end else if (w_commit_here) begin
               r_hist <= w_hist_next;
               if (&w_hist_next) begin
                  r_out_n <= 1'b1;
               end else if (~|w_hist_next) begin
                  r_out_n <= 1'b0;
               end
            end
         end

         assign o_joy_out_n[JOY_BITS*gi + gb] = r_out_n;
      end
`else
      logic [JOY_BITS-1:0] r_out_n;

      always_ff @(posedge i_pclk) begin
         if (!i_reset_n) begin
            r_out_n <= '1;
         end else if (w_commit_here) begin
            r_out_n <= w_capture;
         end
      end

      assign o_joy_out_n[JOY_BITS*gi +: JOY_BITS] = r_out_n;
`endif
   end

   // ---------------------------------------------------------------
   // Coin channels
   // ---------------------------------------------------------------
   for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_coin
      jamma_coin_stretch #(
         .COIN_HOLD (COIN_HOLD)
      ) u_coin (
         .i_pclk    (i_pclk),
         .i_reset_n (i_reset_n),
         .i_coin_n  (i_coin_n[gi]),
         .o_coin_n  (o_coin_out_n[gi])
      );
   end

endmodule

// File: tb/tb_jamma_input_mux.sv
// -----------------------------------------------------------------------------
// tb_jamma_input_mux
// Directed + randomised bench for jamma_input_mux (2 players, settle 1,
// debounce depth 3, coin hold 16). The external bank multiplexer is modelled
// by driving the bus from the DUT's o_jsel each cycle. Expected outputs come
// from a cycle-indexed reference: slot arithmetic for jsel/scan_done, a bus
// history with 2-cycle synchroniser delay for bank captures, and a pin history
// window for the coin stretcher. Build with JAMMA_DEBOUNCE_EN to match a
// debounced DUT.
// -----------------------------------------------------------------------------
module tb_jamma_input_mux;

   localparam int NP     = 2;
   localparam int SEL_W  = 2;
   localparam int SETTLE = 1;
   localparam int DEB    = 3;
   localparam int HOLD   = 16;
   localparam int SLOT   = SETTLE + 2;
   localparam int SCAN   = NP * SLOT;
   localparam int HMAX   = 4096;

   logic              clk;
   logic              reset_n;
   logic [7:0]        jjoy_n;
   logic [7:0]        local_joy_n;
   logic [NP-1:0]     coin_n;
   logic [SEL_W-1:0]  jsel;
   logic [8*NP-1:0]   joy_out_n;
   logic [NP-1:0]     coin_out_n;
   logic              scan_done;

   jamma_input_mux #(
      .NUM_PLAYERS   (NP),
      .SEL_W         (SEL_W),
      .SETTLE_CYCLES (SETTLE),
      .DEB_DEPTH     (DEB),
      .COIN_HOLD     (HOLD)
   ) dut (
      .i_pclk        (clk),
      .i_reset_n     (reset_n),
      .i_jjoy_n      (jjoy_n),
      .i_local_joy_n (local_joy_n),
      .i_coin_n      (coin_n),
      .o_jsel        (jsel),
      .o_joy_out_n   (joy_out_n),
      .o_coin_out_n  (coin_out_n),
      .o_scan_done   (scan_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_err;
   int          k;            // cycles since last reset edge
   int          g;            // global cycle index
   logic [7:0]  bank_val [NP];
   logic [7:0]  exp_joy  [NP];
   logic [7:0]  cap_h    [NP][DEB];
   logic [7:0]  bus_b1;
   logic [7:0]  bus_b2;
   logic [NP-1:0] pin_hist [HMAX];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d: observed %h expected %h", tag, g, obs, exp);
      end
   endtask

   function automatic logic pin_at(input int idx, input int c);
      if (idx < 0 || idx >= HMAX) return 1'b1;
      return pin_hist[idx][c];
   endfunction

   // Coin low at cycle gg if the pin was low 3 cycles ago, or a falling edge
   // occurred within the last HOLD cycles of that delayed view.
   function automatic logic [NP-1:0] coin_expect(input int gg);
      logic [NP-1:0] r;
      r = '1;
      for (int c = 0; c < NP; c++) begin
         if (pin_at(gg - 3, c) == 1'b0) r[c] = 1'b0;
         for (int e = gg - 2 - HOLD; e <= gg - 3; e++) begin
            if (pin_at(e, c) == 1'b0 && pin_at(e - 1, c) == 1'b1) r[c] = 1'b0;
         end
      end
      return r;
   endfunction

   task automatic reset_model();
      for (int p = 0; p < NP; p++) begin
         exp_joy[p] = 8'hFF;
         for (int i = 0; i < DEB; i++) cap_h[p][i] = 8'hFF;
      end
   endtask

   task automatic commit_model(input int p, input logic [7:0] cap);
`ifdef JAMMA_DEBOUNCE_EN
      logic [7:0] all1;
      logic [7:0] any1;
      for (int i = DEB - 1; i > 0; i--) cap_h[p][i] = cap_h[p][i-1];
      cap_h[p][0] = cap;
      all1 = 8'hFF;
      any1 = 8'h00;
      for (int i = 0; i < DEB; i++) begin
         all1 = all1 & cap_h[p][i];
         any1 = any1 | cap_h[p][i];
      end
      exp_joy[p] = (exp_joy[p] | all1) & any1;
`else
      exp_joy[p] = cap;
`endif
   endtask

   task automatic check_all();
      logic [8*NP-1:0] ej;
      int bank;
      bank = (k / SLOT) % NP;
      for (int p = 0; p < NP; p++) ej[8*p +: 8] = exp_joy[p];
      chk("jsel", 32'(jsel), 32'(bank));
      chk("scan_done", 32'(scan_done),
          32'((k % SLOT == SLOT - 1) && (bank == NP - 1)));
      chk("joy_out_n", 32'(joy_out_n), 32'(ej));
      chk("coin_out_n", 32'(coin_out_n), 32'(coin_expect(g)));
   endtask

   // One clock cycle: drive the bus from the external mux, record pins,
   // update the reference for a COMMIT in this cycle, then check.
   task automatic step();
      logic       rst_now;
      logic [7:0] cap;
      int         p;
      if (jsel < SEL_W'(NP)) jjoy_n = bank_val[int'(jsel)];
      else                   jjoy_n = 8'hFF;
      if (g < HMAX) pin_hist[g] = coin_n;
      rst_now = reset_n;
      if (rst_now && (k % SLOT == SLOT - 1)) begin
         p   = (k / SLOT) % NP;
         cap = bus_b2 & ((p == 0) ? local_joy_n : 8'hFF);
         commit_model(p, cap);
      end
      @(posedge clk);
      #1;
      bus_b2 = bus_b1;
      bus_b1 = jjoy_n;
      g++;
      if (!rst_now) begin
         k = 0;
         reset_model();
      end else begin
         k++;
      end
      check_all();
   endtask

   int low_cnt;
   int found;

   initial begin
      n_cmp = 0;
      n_err = 0;
      k = 0;
      g = 0;
      reset_n = 1'b0;
      jjoy_n = 8'hFF;
      local_joy_n = 8'hFF;
      coin_n = '1;
      bus_b1 = 8'hFF;
      bus_b2 = 8'hFF;
      for (int p = 0; p < NP; p++) bank_val[p] = 8'hFF;
      for (int i = 0; i < HMAX; i++) pin_hist[i] = '1;
      reset_model();

      // Reset state
      repeat (3) step();
      chk("rst_jsel", 32'(jsel), 32'd0);
      chk("rst_joy", 32'(joy_out_n), 32'(16'hFFFF));
      chk("rst_coin", 32'(coin_out_n), 32'(2'b11));
      chk("rst_done", 32'(scan_done), 32'd0);
      reset_n = 1'b1;

      // Idle bus
      repeat (2 * SCAN) step();
      chk("idle_joy", 32'(joy_out_n), 32'(16'hFFFF));

      // Distinct bank patterns
      bank_val[0] = 8'hFE;
      bank_val[1] = 8'h7F;
      repeat (3 * SCAN) step();
      chk("bank_pattern", 32'(joy_out_n), 32'(16'h7FFE));

      // Local joystick merged into bank 0 only
      bank_val[0] = 8'hFF;
      bank_val[1] = 8'hFF;
      local_joy_n = 8'hEF;
      repeat (3 * SCAN) step();
      chk("local_merge", 32'(joy_out_n), 32'(16'hFFEF));
      local_joy_n = 8'hFF;
      repeat (3 * SCAN) step();

      // Short glitch then sustained press on bank 0 bit 0
      bank_val[0] = 8'hFE;
      repeat (2 * SCAN) step();
      bank_val[0] = 8'hFF;
      repeat (3 * SCAN) step();
      bank_val[0] = 8'hFE;
      repeat (3 * SCAN) step();
      chk("press_held", 32'(joy_out_n[0]), 32'd0);
      bank_val[0] = 8'hFF;
      repeat (3 * SCAN) step();

      // Coin: single 1-cycle pulse stretches to HOLD cycles
      low_cnt = 0;
      coin_n[0] = 1'b0;
      step();
      if (!coin_out_n[0]) low_cnt++;
      coin_n[0] = 1'b1;
      for (int i = 0; i < HOLD + 10; i++) begin
         step();
         if (!coin_out_n[0]) low_cnt++;
      end
      chk("coin_len", 32'(low_cnt), 32'(HOLD));

      // Coin: second edge 10 cycles later extends the stretch
      low_cnt = 0;
      coin_n[0] = 1'b0;
      step();
      if (!coin_out_n[0]) low_cnt++;
      coin_n[0] = 1'b1;
      for (int i = 1; i < 10; i++) begin
         step();
         if (!coin_out_n[0]) low_cnt++;
      end
      coin_n[0] = 1'b0;
      step();
      if (!coin_out_n[0]) low_cnt++;
      coin_n[0] = 1'b1;
      for (int i = 0; i < HOLD + 12; i++) begin
         step();
         if (!coin_out_n[0]) low_cnt++;
      end
      chk("coin_extend", 32'(low_cnt), 32'(10 + HOLD));

      // Coin held low longer than HOLD on channel 1
      coin_n[1] = 1'b0;
      repeat (HOLD + 9) step();
      coin_n[1] = 1'b1;
      repeat (HOLD + 6) step();

      // Randomised traffic
      for (int i = 0; i < 360; i++) begin
         if (k % SCAN == 0) begin
            for (int p = 0; p < NP; p++)
               if ($urandom_range(0, 2) == 0)
                  bank_val[p] = ~(8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 3) == 0)
               local_joy_n = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
         end
         for (int c = 0; c < NP; c++) begin
            if (coin_n[c]) coin_n[c] = ($urandom_range(0, 11) != 0);
            else           coin_n[c] = ($urandom_range(0, 2) == 0);
         end
         step();
      end
      coin_n = '1;
      local_joy_n = 8'hFF;
      repeat (HOLD + 6) step();

      // Reset during the settle cycle of bank 1
      for (int i = 0; i < SCAN && (k % SCAN != SLOT); i++) step();
      chk("pre_reset_bank1", 32'(jsel), 32'd1);
      reset_n = 1'b0;
      step();
      chk("midrst_jsel", 32'(jsel), 32'd0);
      chk("midrst_joy", 32'(joy_out_n), 32'(16'hFFFF));
      chk("midrst_coin", 32'(coin_out_n), 32'(2'b11));
      chk("midrst_done", 32'(scan_done), 32'd0);
      reset_n = 1'b1;
      found = -1;
      for (int i = 0; i < 3 * SCAN && found < 0; i++) begin
         step();
         if (scan_done === 1'b1) found = k;
      end
      chk("first_done", 32'(found), 32'(SCAN - 1));
      bank_val[1] = 8'hBD;
      repeat (4 * SCAN) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
